// File: rtl/load_store_align_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared encodings for the load/store alignment unit: access
//             size codes, FSM state codes and the lane-geometry helpers
//             (lanes per bus word, lane-offset width).
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SZ_B = 2'd0,
        LSU_SZ_H = 2'd1,
        LSU_SZ_W = 2'd2,
        LSU_SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_BEAT0 = 3'd1,
        LSU_WAIT0 = 3'd2,
        LSU_BEAT1 = 3'd3,
        LSU_WAIT1 = 3'd4,
        LSU_DONE  = 3'd5
    } lsu_state_e;

    // Byte lanes per bus word.
    function automatic int lsu_nb(input int xlen, input int byte_width);
        return xlen / byte_width;
    endfunction

    // Width of the in-word byte offset.
    function automatic int lsu_offw(input int xlen, input int byte_width);
        return $clog2(xlen / byte_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_align_unit_if
//  Purpose  : Request/response and data-memory bus bundle of the load/store
//             alignment unit.
//  Ports    : req_*  - one load/store request per transaction
//             resp_* - completion pulse, extended load data, trap flag
//             mem_*  - aligned, byte-enabled memory beat port
//  Modports : slave  - the alignment unit
//             master - execute stage plus data memory (the environment)
//  Revision : 1.0 - initial release
// ============================================================================
interface load_store_align_unit_if #(
    parameter int XLEN       = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = XLEN / BYTE_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [XLEN-1:0]       req_wdata;

    logic                  resp_valid;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_misaligned;

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NB-1:0]         mem_be;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_rvalid;
    logic [XLEN-1:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/load_store_align_unit_load_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_formatter
//  Purpose  : Combinational load-data merge: joins the two beat words at the
//             byte offset, masks to the access size and zero/sign-extends.
//  Ports    : i_rdata0/i_rdata1 - first/second beat read words
//             i_off             - byte offset of the access in beat 0
//             i_size            - access size code (already clamped to XLEN)
//             i_unsigned        - zero-extend instead of sign-extend
//             o_rdata           - extended load result
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_load_formatter
    import lsu_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int BYTE_WIDTH = 8,
    localparam int OFFW       = lsu_offw(XLEN, BYTE_WIDTH)
) (
    input  logic [XLEN-1:0] i_rdata0,
    input  logic [XLEN-1:0] i_rdata1,
    input  logic [OFFW-1:0] i_off,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_rdata
);
    localparam int c_idx_w = $clog2(XLEN);

    logic [XLEN-1:0]    w_raw;
    logic [XLEN-1:0]    w_mask;
    logic [c_idx_w-1:0] w_sidx;
    logic               w_sign;
    int                 w_nbits;

    always_comb begin
        // Shifting the concatenated pair right by the offset equals
        // (rdata0 >> off) | (rdata1 << (NB-off)) in one operation.
        w_raw   = XLEN'({i_rdata1, i_rdata0} >> (32'(i_off) * BYTE_WIDTH));
        w_nbits = (32'd1 << i_size) * BYTE_WIDTH;
        // A full-width access shifts the 1 out entirely; 0 - 1 gives all ones.
        w_mask  = (XLEN'(1) << w_nbits) - XLEN'(1);
        w_sidx  = c_idx_w'(w_nbits - 1);
        w_sign  = w_raw[w_sidx] & ~i_unsigned;
        o_rdata = (w_raw & w_mask) | (w_sign ? ~w_mask : '0);
    end

endmodule
`default_nettype wire

// File: rtl/load_store_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_align_unit
//  Purpose  : Accepts one load/store at a time, drives aligned byte-enabled
//             memory beats, splits word-crossing accesses into two beats and
//             returns merged, extended load data.
//  Ports    : clk, rst (synchronous, active-high)
//             bus       - load_store_align_unit_if.slave (req/resp/mem)
//  Config   : `define LSU_MISALIGN_TRAP_EN to trap crossing accesses instead
//             of splitting them (no beats, resp_misaligned=1, rdata=0).
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_align_unit
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_align_unit_if.slave  bus
);
    localparam int NB        = lsu_nb(XLEN, BYTE_WIDTH);
    localparam int OFFW      = lsu_offw(XLEN, BYTE_WIDTH);
    localparam int c_end_w   = OFFW + 2;
    localparam int c_lanes_w = 2 * NB;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit c_trap_en = 1'b1;
`else
    localparam bit c_trap_en = 1'b0;
`endif

    lsu_state_e            r_state, w_state_nxt;
    logic                  r_we, r_unsigned, r_cross;
    logic [1:0]            r_size;
    logic [OFFW-1:0]       r_off;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [XLEN-1:0]       r_wdata, r_rdata0, r_rdata1;

    logic [1:0]            w_req_size;
    logic [OFFW-1:0]       w_req_off;
    logic [c_end_w-1:0]    w_req_end;
    logic                  w_req_cross;
    logic                  w_accept;
    logic [c_lanes_w-1:0]  w_lanes;
    logic [2*XLEN-1:0]     w_wdata_wide;
    logic [XLEN-1:0]       w_fmt;

    // Request decode; a double on a 32-bit datapath behaves as a word.
    always_comb begin
        w_req_size = bus.req_size;
        if (XLEN == 32 && bus.req_size == LSU_SZ_D) begin
            w_req_size = LSU_SZ_W;
        end
        w_req_off   = bus.req_addr[OFFW-1:0];
        w_req_end   = c_end_w'(w_req_off) + (c_end_w'(1) << w_req_size);
        w_req_cross = w_req_end > c_end_w'(NB);
        w_accept    = bus.req_valid && (r_state == LSU_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LSU_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_cross    <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_unsigned <= bus.req_unsigned;
                r_cross    <= w_req_cross;
                r_size     <= w_req_size;
                r_off      <= w_req_off;
                r_base     <= {bus.req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                r_wdata    <= bus.req_wdata;
                r_rdata0   <= '0;
                r_rdata1   <= '0;
            end
            if (r_state == LSU_WAIT0 && bus.mem_rvalid) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (r_state == LSU_WAIT1 && bus.mem_rvalid) begin
                r_rdata1 <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = (c_trap_en && w_req_cross) ? LSU_DONE : LSU_BEAT0;
                end
            end
            LSU_BEAT0: begin
                if (bus.mem_ready) begin
                    if (!r_we)        w_state_nxt = LSU_WAIT0;
                    else if (r_cross) w_state_nxt = LSU_BEAT1;
                    else              w_state_nxt = LSU_DONE;
                end
            end
            LSU_WAIT0: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = r_cross ? LSU_BEAT1 : LSU_DONE;
                end
            end
            LSU_BEAT1: begin
                if (bus.mem_ready) begin
                    w_state_nxt = r_we ? LSU_DONE : LSU_WAIT1;
                end
            end
            LSU_WAIT1: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = LSU_DONE;
                end
            end
            LSU_DONE: w_state_nxt = LSU_IDLE;
            default:  w_state_nxt = LSU_IDLE;
        endcase
    end

    // Lane enables and write data for both beats are formed as one
    // double-width word: the low half is beat 0, the high half is beat 1.
    always_comb begin
        w_lanes      = ((c_lanes_w'(1) << (32'd1 << r_size)) - c_lanes_w'(1)) << r_off;
        w_wdata_wide = {{XLEN{1'b0}}, r_wdata} << (32'(r_off) * BYTE_WIDTH);
    end

    lsu_load_formatter #(
        .XLEN       (XLEN),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_load_formatter (
        .i_rdata0   (r_rdata0),
        .i_rdata1   (r_rdata1),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_rdata    (w_fmt)
    );

    always_comb begin
        bus.req_ready       = (r_state == LSU_IDLE);
        bus.mem_valid       = 1'b0;
        bus.mem_we          = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_be          = '0;
        bus.mem_wdata       = '0;
        bus.resp_valid      = (r_state == LSU_DONE);
        bus.resp_misaligned = (r_state == LSU_DONE) && c_trap_en && r_cross;
        bus.resp_rdata      = '0;
        if (r_state == LSU_BEAT0) begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = r_we;
            bus.mem_addr  = r_base;
            bus.mem_be    = w_lanes[NB-1:0];
            bus.mem_wdata = r_we ? w_wdata_wide[XLEN-1:0] : '0;
        end
        if (r_state == LSU_BEAT1) begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = r_we;
            bus.mem_addr  = r_base + ADDR_WIDTH'(NB);
            bus.mem_be    = w_lanes[c_lanes_w-1:NB];
            bus.mem_wdata = r_we ? w_wdata_wide[2*XLEN-1:XLEN] : '0;
        end
        if (r_state == LSU_DONE && !r_we && !(c_trap_en && r_cross)) begin
            bus.resp_rdata = w_fmt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_align_unit
//  Purpose  : Directed self-checking bench for load_store_align_unit, XLEN=32.
//             Honours LSU_MISALIGN_TRAP_EN for the crossing-access steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_align_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_align_unit_if #(.XLEN(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)) bus ();

    load_store_align_unit #(.XLEN(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Captured beats and response of the last zero-wait transaction.
    logic [31:0] b_addr  [4];
    logic [3:0]  b_be    [4];
    logic [31:0] b_wdata [4];
    logic        b_we    [4];
    int          nbeats;
    int          lat;
    logic [31:0] got_rdata;
    logic        got_mis;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction against a zero-wait memory (ready always 1, read data
    // the cycle after a read beat is accepted). Cycle 0 is the accept edge.
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] d0, input logic [31:0] d1);
        int pend;
        nbeats = 0; lat = -1; got_rdata = '0; got_mis = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        pend = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (pend >= 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = (pend == 0) ? d0 : d1;
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end
            pend = -1;
            if (cyc == 1) check("req_ready_busy", bus.req_ready, 0);
            if (bus.mem_valid) begin
                if (nbeats < 4) begin
                    b_addr[nbeats] = bus.mem_addr; b_be[nbeats] = bus.mem_be;
                    b_wdata[nbeats] = bus.mem_wdata; b_we[nbeats] = bus.mem_we;
                end
                if (!bus.mem_we) pend = nbeats;
                nbeats++;
            end
            if (bus.resp_valid) begin
                lat = cyc; got_rdata = bus.resp_rdata; got_mis = bus.resp_misaligned;
            end
            @(negedge clk);
            if (lat >= 0) break;
        end
        bus.mem_rvalid = 1'b0;
        check("req_ready_after_done", bus.req_ready, 1);
        check("resp_valid_one_cycle", bus.resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_cyc;
        logic [31:0] rst_addr;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.mem_ready = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_mis", bus.resp_misaligned, 0);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Signed LB at 0x1003
        txn(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80AABBCC, 32'h0);
        check("lb_beats", nbeats, 1);
        check("lb_addr", b_addr[0], 32'h1000);
        check("lb_be", b_be[0], 4'b1000);
        check("lb_we", b_we[0], 0);
        check("lb_lat", lat, 3);
        check("lb_rdata", got_rdata, 32'hFFFFFF80);

        // LHU at 0x1002
        txn(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'hBEEF1234, 32'h0);
        check("lhu_be", b_be[0], 4'b1100);
        check("lhu_rdata", got_rdata, 32'h0000BEEF);

        // Signed LH at 0x1000 and unsigned LB at 0x1001
        txn(1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, 32'h12348001, 32'h0);
        check("lh_be", b_be[0], 4'b0011);
        check("lh_rdata", got_rdata, 32'hFFFF8001);
        txn(1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 32'h80AABBCC, 32'h0);
        check("lbu_rdata", got_rdata, 32'h000000BB);

        // LW at 0x1003 (crossing); size 3 must behave as a word
        txn(1'b0, 2'd3, 1'b0, 32'h1003, 32'h0, 32'h11223344, 32'h55667788);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lwx_beats", nbeats, 0);
        check("lwx_lat", lat, 1);
        check("lwx_mis", got_mis, 1);
        check("lwx_rdata", got_rdata, 0);
`else
        check("lwx_beats", nbeats, 2);
        check("lwx_addr0", b_addr[0], 32'h1000);
        check("lwx_be0", b_be[0], 4'b1000);
        check("lwx_addr1", b_addr[1], 32'h1004);
        check("lwx_be1", b_be[1], 4'b0111);
        check("lwx_lat", lat, 5);
        check("lwx_mis", got_mis, 0);
        check("lwx_rdata", got_rdata, 32'h66778811);
`endif

        // SH at 0x1007 (crossing store)
        txn(1'b1, 2'd1, 1'b0, 32'h1007, 32'h0000ABCD, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("shx_beats", nbeats, 0);
        check("shx_lat", lat, 1);
        check("shx_mis", got_mis, 1);
`else
        check("shx_beats", nbeats, 2);
        check("shx_addr0", b_addr[0], 32'h1004);
        check("shx_be0", b_be[0], 4'b1000);
        check("shx_wdata0", b_wdata[0], 32'hCD000000);
        check("shx_we0", b_we[0], 1);
        check("shx_addr1", b_addr[1], 32'h1008);
        check("shx_be1", b_be[1], 4'b0001);
        check("shx_wdata1", b_wdata[1], 32'h000000AB);
        check("shx_lat", lat, 3);
`endif
        check("shx_rdata", got_rdata, 0);

        // Aligned SW at 0x2004
        txn(1'b1, 2'd2, 1'b0, 32'h2004, 32'hDEADBEEF, 32'h0, 32'h0);
        check("sw_beats", nbeats, 1);
        check("sw_addr", b_addr[0], 32'h2004);
        check("sw_be", b_be[0], 4'b1111);
        check("sw_wdata", b_wdata[0], 32'hDEADBEEF);
        check("sw_lat", lat, 2);
        check("sw_rdata", got_rdata, 0);

        // Aligned LW with mem_ready low for 3 cycles; a second request while busy
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h2000; bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req_addr = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            check("stall_mem_valid", bus.mem_valid, 1);
            check("stall_mem_addr", bus.mem_addr, 32'h2000);
            check("stall_mem_be", bus.mem_be, 4'b1111);
            check("stall_mem_we", bus.mem_we, 0);
            check("stall_req_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("stall_wait_mem_valid", bus.mem_valid, 0);
        check("stall_wait_req_ready", bus.req_ready, 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("stall_resp_valid", bus.resp_valid, 1);
        check("stall_resp_rdata", bus.resp_rdata, 32'hCAFEF00D);
        @(negedge clk);
        check("stall_idle_ready", bus.req_ready, 1);
        @(negedge clk);
        check("stall_no_second_req", bus.mem_valid, 0);

        // Reset in a read-wait state, then a stale mem_rvalid
`ifdef LSU_MISALIGN_TRAP_EN
        rst_addr = 32'h1000; rst_cyc = 2;
`else
        rst_addr = 32'h1003; rst_cyc = 4;
`endif
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_addr = rst_addr; bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc < rst_cyc; cyc++) begin
            bus.mem_rvalid = (cyc == 2); bus.mem_rdata = 32'h11223344;
            check("rstmid_no_resp", bus.resp_valid, 0);
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        check("rstmid_wait_state", bus.mem_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55667788;
        check("rstmid_req_ready", bus.req_ready, 1);
        check("rstmid_mem_valid", bus.mem_valid, 0);
        check("rstmid_resp_valid", bus.resp_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            check("rstmid_never_resp", bus.resp_valid, 0);
            check("rstmid_stays_idle", bus.req_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
